// File: rtl/ttl_74194_pkg.sv
// Shared constants for the 74194-style universal shift register.
`timescale 1ns / 1ps

package ttl_74194_pkg;

   localparam int unsigned DefWidth  = 4;
   localparam int unsigned ModeWidth = 2;

endpackage

// File: rtl/ttl_74194.sv
// Universal shift register: hold, shift right, shift left, parallel load, async active-low clear.
// Q carries separate rise and fall delays per bit.
`timescale 1ns / 1ps

module ttl_74194
   import ttl_74194_pkg::*;
#(
   parameter int unsigned WIDTH      = DefWidth,
   parameter int unsigned DELAY_RISE = 0,
   parameter int unsigned DELAY_FALL = 0
) (
   input  logic                 Clk,
   input  logic                 Clear_bar,
   input  logic [ModeWidth-1:0] S,
   input  logic                 DSR,
   input  logic                 DSL,
   input  logic [WIDTH-1:0]     D,
   output logic [WIDTH-1:0]     Q
);

   localparam logic [ModeWidth-1:0] MODE_HOLD  = 2'b00;
   localparam logic [ModeWidth-1:0] MODE_RIGHT = 2'b01;
   localparam logic [ModeWidth-1:0] MODE_LEFT  = 2'b10;
   localparam logic [ModeWidth-1:0] MODE_LOAD  = 2'b11;

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_rise;
   logic [WIDTH-1:0] q_fall;

   always_comb begin
      q_d = q_q;
      case (S)
         MODE_HOLD:  q_d = q_q;
         MODE_RIGHT: q_d = {q_q[WIDTH-2:0], DSR};
         MODE_LEFT:  q_d = {DSL, q_q[WIDTH-1:1]};
         MODE_LOAD:  q_d = D;
         // Unknown mode select corrupts the whole register.
         default:    q_d = 'x;
      endcase
   end

   always_ff @(posedge Clk or negedge Clear_bar) begin
      if (!Clear_bar) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign #(DELAY_RISE) q_rise = q_q;
   assign #(DELAY_FALL) q_fall = q_q;

   // A bit now 1 follows the rise-delayed copy, a bit now 0 the fall-delayed one,
   // so steady bits never glitch.
   assign Q = (q_q & q_rise) | (~q_q & q_fall);

endmodule

// File: tb/tb_ttl_74194.sv
// Directed bench for ttl_74194 (WIDTH=4, rise 5, fall 3, period 100).
`timescale 1ns / 1ps

module tb_ttl_74194;

   logic       clk;
   logic       clear_bar;
   logic [1:0] s;
   logic       dsr;
   logic       dsl;
   logic       tie_dsl;
   logic       dsl_w;
   logic [3:0] d;
   logic [3:0] q;

   int n_pass;
   int n_total;
   logic four_state;
   logic probe;
   logic [3:0] all_x;

   ttl_74194 #(
      .WIDTH      (4),
      .DELAY_RISE (5),
      .DELAY_FALL (3)
   ) dut (
      .Clk       (clk),
      .Clear_bar (clear_bar),
      .S         (s),
      .DSR       (dsr),
      .DSL       (dsl_w),
      .D         (d),
      .Q         (q)
   );

   assign dsl_w = tie_dsl ? q[0] : dsl;

   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   // Wait for the next rising edge and settle past both output delays.
   task automatic step();
      @(posedge clk);
      #6;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] exp_r [4];
      logic [3:0] exp_l [4];
      exp_r = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
      exp_l = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
      n_pass     = 0;
      n_total    = 0;
      probe      = 1'bx;
      four_state = $isunknown(probe);
      all_x      = 'x;
      clear_bar  = 1'b1;
      s          = 2'b00;
      d          = 4'b0000;
      dsr        = 1'b0;
      dsl        = 1'b0;
      tie_dsl    = 1'b0;

      // 1. Power-up and asynchronous clear
      #10;
      if (four_state) check("powerup_x", q, all_x);
      #70;
      clear_bar = 1'b0;
      #2;
      if (four_state) check("clear_pre_fall", q, all_x);
      #2;
      check("clear_async", q, 4'b0000);
      s = 2'b11;
      d = 4'b1111;
      step();
      check("clear_edge1", q, 4'b0000);
      step();
      check("clear_edge2", q, 4'b0000);

      // 2. Load with rise delay, then hold while inputs wiggle
      clear_bar = 1'b1;
      s = 2'b11;
      d = 4'b1010;
      @(posedge clk);
      #4;
      check("load_before_rise", q, 4'b0000);
      #2;
      check("load_after_rise", q, 4'b1010);
      s = 2'b00;
      for (int i = 0; i < 3; i++) begin
         d   = ~d;
         dsr = ~dsr;
         dsl = ~dsl;
         #20;
         d   = ~d;
         dsr = ~dsr;
         step();
      end
      check("hold_3_edges", q, 4'b1010);

      // 3. Right shift from zero
      clear_bar = 1'b0;
      #10;
      clear_bar = 1'b1;
      s   = 2'b01;
      dsr = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("shift_right_ones", q, exp_r[i]);
      end
      dsr = 1'b0;
      step();
      check("shift_right_zero", q, 4'b1110);

      // 4. Left shift from zero, then rotate via external tie
      clear_bar = 1'b0;
      #10;
      clear_bar = 1'b1;
      s   = 2'b10;
      dsl = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("shift_left_ones", q, exp_l[i]);
      end
      dsl = 1'b0;
      step();
      check("shift_left_zero", q, 4'b0111);
      s = 2'b11;
      d = 4'b0001;
      step();
      check("rot_load", q, 4'b0001);
      s = 2'b10;
      tie_dsl = 1'b1;
      step();
      check("rot_left_1", q, 4'b1000);
      step();
      check("rot_left_2", q, 4'b0100);
      tie_dsl = 1'b0;

      // 5. Mid-cycle clear pulse during right shifting
      clear_bar = 1'b0;
      #10;
      clear_bar = 1'b1;
      s   = 2'b01;
      dsr = 1'b1;
      step();
      step();
      check("pre_pulse", q, 4'b0011);
      #40;
      clear_bar = 1'b0;
      #3.001;
      check("pulse_clear", q, 4'b0000);
      #16.999;
      clear_bar = 1'b1;
      step();
      check("after_pulse", q, 4'b0001);
      clear_bar = 1'b0;
      s = 2'b11;
      d = 4'b1111;
      @(posedge clk);
      clear_bar <= 1'b1;
      #6;
      check("release_at_edge", q, 4'b0000);
      step();
      check("load_after_release", q, 4'b1111);

      // 6. Unknown mode and recovery
      if (four_state) begin
         s = 2'bx1;
         step();
         check("mode_x", q, all_x);
      end
      s = 2'b11;
      d = 4'b0101;
      step();
      check("recover_load", q, 4'b0101);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
